// File: rtl/core_arf_dbg_if.sv
// Front-panel command/response channel of the register-file debug controller.
interface core_arf_dbg_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [3:0]  cmd_addr_i;
    logic [15:0] cmd_data_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [3:0]  rsp_addr_o;
    logic [15:0] rsp_data_o;
    logic        rsp_err_o;

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, rsp_ready_i,
        output cmd_ready_o, rsp_valid_o, rsp_addr_o, rsp_data_o, rsp_err_o
    );

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, rsp_ready_i,
        input  cmd_ready_o, rsp_valid_o, rsp_addr_o, rsp_data_o, rsp_err_o
    );
endinterface

// File: rtl/core_arf_dbg.sv
// Debug LOOK/DEPOSIT controller for the 16x16 architectural register file.
// Halts the core, performs one access, and holds the halt until the response is taken.
module core_arf_dbg #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    core_arf_dbg_if.slave         dbg,
    output logic                  halt_req_o,
    input  logic                  halted_i,
    output logic [3:0]            arf_r_addr_o,
    input  logic [15:0]           arf_r_data_i,
    output logic                  arf_w_en_o,
    output logic [3:0]            arf_w_addr_o,
    output logic [15:0]           arf_w_data_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HALT_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_dep;
    logic [3:0]  r_ptr;
    logic [3:0]  r_target;
    logic [15:0] r_data;
    logic [15:0] r_cnt;
    logic        r_halt_req;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [3:0]  r_rsp_addr;
    logic [15:0] r_rsp_data;

    logic        w_accept;
    logic        w_timeout;
    logic        w_r0_dep;

    assign w_accept  = (r_state == S_IDLE) && dbg.cmd_valid_i && !rst_i;
    assign w_timeout = (r_cnt == TO_LAST);
    assign w_r0_dep  = r_dep && (r_target == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_HALT_WAIT;
            end
            S_HALT_WAIT: begin
                if (halted_i)       w_next = S_ACCESS;
                else if (w_timeout) w_next = S_RESP;
            end
            S_ACCESS: w_next = S_RESP;
            S_RESP: begin
                if (dbg.rsp_ready_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dep       <= 1'b0;
            r_ptr       <= '0;
            r_target    <= '0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_halt_req  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
        end else begin
            // halt stays requested from HALT_WAIT through the RESP handshake
            r_halt_req  <= (w_next != S_IDLE);
            r_rsp_valid <= (w_next == S_RESP);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dep    <= dbg.cmd_op_i[0];
                        r_data   <= dbg.cmd_data_i;
                        r_target <= dbg.cmd_op_i[1] ? r_ptr + 4'd1 : dbg.cmd_addr_i;
                        r_cnt    <= '0;
                    end
                end
                S_HALT_WAIT: begin
                    if (!halted_i) begin
                        if (w_timeout) begin
                            r_rsp_err  <= 1'b1;
                            r_rsp_data <= '0;
                            r_rsp_addr <= r_target;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                S_ACCESS: begin
                    r_ptr      <= r_target;
                    r_rsp_addr <= r_target;
                    r_rsp_err  <= w_r0_dep;
                    if (w_r0_dep)   r_rsp_data <= '0;
                    else if (r_dep) r_rsp_data <= r_data;
                    else            r_rsp_data <= arf_r_data_i;
                end
                default: ;
            endcase
        end
    end

    assign dbg.cmd_ready_o = (r_state == S_IDLE) && !rst_i;
    assign dbg.rsp_valid_o = r_rsp_valid;
    assign dbg.rsp_addr_o  = r_rsp_addr;
    assign dbg.rsp_data_o  = r_rsp_data;
    assign dbg.rsp_err_o   = r_rsp_err;

    assign halt_req_o   = r_halt_req;
    assign arf_r_addr_o = r_target;
    assign arf_w_en_o   = (r_state == S_ACCESS) && r_dep && !w_r0_dep;
    assign arf_w_addr_o = r_target;
    assign arf_w_data_o = r_data;

endmodule
